mem_stage: RTL and testbench

Fourth pipeline stage of the 32-bit MIPS core: receives the EX-stage outputs (ALU result, store data, destination register, MEM/WB control bits), holds them in the EX/MEM register and performs the data-memory load or store over a req/ack handshake. It stalls the upstream pipeline while memory is busy and holds the MEM/WB register that feeds write-back. It also drives the two forwarding sources `ALUop_inMEM` and `MUXop_inWB` back into the EX stage.

---
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 32-bit MIPS pipeline: EX/MEM register, data-memory req/ack
// access FSM with timeout, and the MEM/WB register feeding write-back.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] Result,
    input  logic [31:0] OutB,
    input  logic [4:0]  WriteReg,
    input  logic [3:0]  MEMReg,
    input  logic [1:0]  WBReg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALUop_inMEM,
    output logic        mem_regwrite,
    output logic [4:0]  mem_writereg,
    output logic [31:0] MUXop_inWB,
    output logic        wb_regwrite,
    output logic [4:0]  wb_writereg,
    output logic        bus_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q;

    logic [31:0] exm_result_q, exm_result_d;
    logic [31:0] exm_wdata_q, exm_wdata_d;
    logic [4:0]  exm_wreg_q, exm_wreg_d;
    logic        exm_memwrite_q, exm_memwrite_d;
    logic        exm_memread_q, exm_memread_d;
    logic        exm_regwrite_q, exm_regwrite_d;
    logic        exm_memtoreg_q, exm_memtoreg_d;

    logic [31:0] wb_val_q, wb_val_d;
    logic [4:0]  wb_wreg_q, wb_wreg_d;
    logic        wb_regwrite_q, wb_regwrite_d;

    logic        mem_op, timeout, req, done, stall;
    logic [31:0] load_data;
    logic        unused_memreg;

    assign unused_memreg = ^MEMReg[3:2];

    // The access is abandoned once req has been high MAX_WAIT cycles; in WAIT,
    // cnt_q+1 req cycles have already elapsed before the current one.
    assign mem_op    = exm_memwrite_q | exm_memread_q;
    assign timeout   = (state_q == S_WAIT) && (cnt_q == 8'(MAX_WAIT - 1));
    assign req       = mem_op & ~timeout;
    assign done      = (req & dmem_ack) | timeout;
    assign stall     = mem_op & ~done;
    assign load_data = timeout ? 32'h0 : dmem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'h0;
        case (state_q)
            S_IDLE: begin
                if (req && !dmem_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done || !mem_op) state_d = S_IDLE;
                else                 cnt_d   = cnt_q + 8'h1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        exm_result_d   = exm_result_q;
        exm_wdata_d    = exm_wdata_q;
        exm_wreg_d     = exm_wreg_q;
        exm_memwrite_d = exm_memwrite_q;
        exm_memread_d  = exm_memread_q;
        exm_regwrite_d = exm_regwrite_q;
        exm_memtoreg_d = exm_memtoreg_q;
        wb_val_d       = 32'h0;
        wb_wreg_d      = 5'h0;
        wb_regwrite_d  = 1'b0;
        if (!stall) begin
            exm_result_d   = ex_valid ? Result    : 32'h0;
            exm_wdata_d    = ex_valid ? OutB      : 32'h0;
            exm_wreg_d     = ex_valid ? WriteReg  : 5'h0;
            exm_memwrite_d = ex_valid & MEMReg[0];
            exm_memread_d  = ex_valid & MEMReg[1];
            exm_regwrite_d = ex_valid & WBReg[1];
            exm_memtoreg_d = ex_valid & WBReg[0];
            wb_val_d       = exm_memtoreg_q ? load_data : exm_result_q;
            wb_wreg_d      = exm_wreg_q;
            wb_regwrite_d  = exm_regwrite_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'h0;
            bus_err_q      <= 1'b0;
            exm_result_q   <= 32'h0;
            exm_wdata_q    <= 32'h0;
            exm_wreg_q     <= 5'h0;
            exm_memwrite_q <= 1'b0;
            exm_memread_q  <= 1'b0;
            exm_regwrite_q <= 1'b0;
            exm_memtoreg_q <= 1'b0;
            wb_val_q       <= 32'h0;
            wb_wreg_q      <= 5'h0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_err_q      <= bus_err_q | timeout;
            exm_result_q   <= exm_result_d;
            exm_wdata_q    <= exm_wdata_d;
            exm_wreg_q     <= exm_wreg_d;
            exm_memwrite_q <= exm_memwrite_d;
            exm_memread_q  <= exm_memread_d;
            exm_regwrite_q <= exm_regwrite_d;
            exm_memtoreg_q <= exm_memtoreg_d;
            wb_val_q       <= wb_val_d;
            wb_wreg_q      <= wb_wreg_d;
            wb_regwrite_q  <= wb_regwrite_d;
        end
    end

    assign mem_stall    = stall;
    assign dmem_req     = req;
    assign dmem_we      = req & exm_memwrite_q;
    assign dmem_addr    = {exm_result_q[31:2], 2'b00};
    assign dmem_wdata   = exm_wdata_q;
    assign ALUop_inMEM  = exm_result_q;
    assign mem_regwrite = exm_regwrite_q;
    assign mem_writereg = exm_wreg_q;
    assign MUXop_inWB   = wb_val_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_writereg  = wb_wreg_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: instruction stream with per-access ack latency,
// checked against a transaction-level model of the MEM stage.
module tb_mem_stage;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] Result, OutB;
    logic [4:0]  WriteReg;
    logic [3:0]  MEMReg;
    logic [1:0]  WBReg;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] ALUop_inMEM, MUXop_inWB;
    logic        mem_regwrite, wb_regwrite, bus_err;
    logic [4:0]  mem_writereg, wb_writereg;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .Result(Result), .OutB(OutB),
        .WriteReg(WriteReg), .MEMReg(MEMReg), .WBReg(WBReg), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .ALUop_inMEM(ALUop_inMEM), .mem_regwrite(mem_regwrite),
        .mem_writereg(mem_writereg), .MUXop_inWB(MUXop_inWB),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .bus_err(bus_err)
    );

    typedef struct {
        logic        v;
        logic [31:0] res, outb, rdata;
        logic [4:0]  wreg;
        logic        mw, mr, rw, m2r;
        int          lat;
    } ins_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ins_t bub();
        ins_t b;
        b.v = 1'b0; b.res = 32'h0; b.outb = 32'h0; b.rdata = 32'h0; b.wreg = 5'h0;
        b.mw = 1'b0; b.mr = 1'b0; b.rw = 1'b0; b.m2r = 1'b0; b.lat = 0;
        return b;
    endfunction

    function automatic ins_t mk(input logic [31:0] res, input logic [31:0] outb,
                                input logic [31:0] rdata, input logic [4:0] wreg,
                                input logic mw, input logic mr, input logic rw,
                                input logic m2r, input int lat);
        ins_t n;
        n.v = 1'b1; n.res = res; n.outb = outb; n.rdata = rdata; n.wreg = wreg;
        n.mw = mw; n.mr = mr; n.rw = rw; n.m2r = m2r; n.lat = lat;
        return n;
    endfunction

    task automatic drive(input ins_t n);
        if (n.v) begin
            ex_valid = 1'b1; Result = n.res; OutB = n.outb; WriteReg = n.wreg;
            MEMReg = {2'($urandom), n.mr, n.mw}; WBReg = {n.rw, n.m2r};
        end else begin
            ex_valid = 1'b0; Result = $urandom; OutB = $urandom; WriteReg = 5'($urandom);
            MEMReg = 4'($urandom); WBReg = 2'($urandom);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk_eq({pfx, "_req"},    32'(dmem_req), 32'h0);
        chk_eq({pfx, "_stall"},  32'(mem_stall), 32'h0);
        chk_eq({pfx, "_we"},     32'(dmem_we), 32'h0);
        chk_eq({pfx, "_addr"},   dmem_addr, 32'h0);
        chk_eq({pfx, "_wdata"},  dmem_wdata, 32'h0);
        chk_eq({pfx, "_aluop"},  ALUop_inMEM, 32'h0);
        chk_eq({pfx, "_mrw"},    32'({mem_regwrite, mem_writereg}), 32'h0);
        chk_eq({pfx, "_wbval"},  MUXop_inWB, 32'h0);
        chk_eq({pfx, "_wbrw"},   32'({wb_regwrite, wb_writereg}), 32'h0);
        chk_eq({pfx, "_buserr"}, 32'(bus_err), 32'h0);
    endtask

    ins_t        prog[$];
    ins_t        cur, nxt, ld;
    int          ptr, c, k, cyc, r;
    logic        memop, ack_now, to_now, exp_stall, exp_req, errx;
    logic [31:0] wbv;
    logic [4:0]  wbw;
    logic        wbr;

    initial begin
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        drive(bub());
        #12;
        chk_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;

        // Directed cases first, then a random stream, then drain bubbles.
        prog.push_back(mk(32'h10, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 0));
        prog.push_back(mk(32'h103, 32'h0, 32'hCAFEF00D, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 0));
        prog.push_back(mk(32'h2008, 32'h0, 32'h600DF00D, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 3));
        prog.push_back(mk(32'h300, 32'h12345678, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        prog.push_back(bub());
        prog.push_back(mk(32'h44, 32'h0, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 100));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) prog.push_back(bub());
            else begin
                r = $urandom_range(0, 3);
                prog.push_back(mk($urandom, $urandom, $urandom, 5'($urandom),
                                  r >= 2, r == 1 || r == 3, r == 0 || r == 1 ? 1'($urandom) : 1'b0,
                                  r == 1, $urandom_range(0, 5)));
            end
        end
        prog.push_back(bub());
        prog.push_back(bub());

        @(posedge clk); #1;
        ptr = 0; c = 0; cyc = 0; cur = bub();
        wbv = 32'h0; wbw = 5'h0; wbr = 1'b0; errx = 1'b0;
        while (ptr < prog.size()) begin
            nxt = prog[ptr];
            drive(nxt);
            memop   = cur.mw | cur.mr;
            k       = memop ? ((cur.lat < MW) ? cur.lat : MW) : 0;
            ack_now = memop && (c == cur.lat) && (cur.lat < MW);
            to_now  = memop && (c == MW);
            exp_stall = memop && (c < k);
            exp_req   = memop && (c < MW);
            // An ack offered while no request is outstanding must be ignored.
            dmem_ack   = ack_now ? 1'b1 : (exp_req ? 1'b0 : 1'($urandom));
            dmem_rdata = ack_now ? cur.rdata : $urandom;
            #1;
            chk_eq("stall", 32'(mem_stall), 32'(exp_stall));
            chk_eq("req", 32'(dmem_req), 32'(exp_req));
            chk_eq("we", 32'(dmem_we), 32'(exp_req && cur.mw));
            if (memop) begin
                chk_eq("addr", dmem_addr, {cur.res[31:2], 2'b00});
                chk_eq("wdata", dmem_wdata, cur.outb);
            end
            @(posedge clk); #1;
            if (!exp_stall) begin
                wbv = cur.m2r ? (to_now ? 32'h0 : cur.rdata) : cur.res;
                wbr = cur.rw; wbw = cur.wreg;
                cur = nxt.v ? nxt : bub();
                ptr++; c = 0;
            end else begin
                wbv = 32'h0; wbr = 1'b0; wbw = 5'h0;
                c++;
            end
            if (to_now) errx = 1'b1;
            chk_eq("aluop", ALUop_inMEM, cur.res);
            chk_eq("mem_rw", 32'({mem_regwrite, mem_writereg}), 32'({cur.rw, cur.wreg}));
            chk_eq("wb_val", MUXop_inWB, wbv);
            chk_eq("wb_rw", 32'({wb_regwrite, wb_writereg}), 32'({wbr, wbw}));
            chk_eq("bus_err", 32'(bus_err), 32'(errx));
            cyc++;
            if (cyc > 5000) begin
                chk_eq("cycle_budget", 32'(cyc), 32'd5000);
                break;
            end
        end

        // Reset in the middle of a waiting load.
        ld = mk(32'h500, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 100);
        drive(ld); dmem_ack = 1'b0;
        @(posedge clk); #1;
        drive(bub());
        #1;
        chk_eq("mid_req", 32'(dmem_req), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_reset_outputs("late_ack");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
